key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 240000, SHALL be the number of consecutive stable clocks required to accept a change (20 ms at 12 MHz); legal range 2..2^24.
REQ-002 Parameter KEY_ACTIVE_LOW, default 1, SHALL mean raw key=0 is pressed when 1, and raw key=1 is pressed when 0.
REQ-003 clk  in  1  single system clock; all logic SHALL run on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 key  in  4  raw push-button pads, asynchronous to clk.
REQ-006 sw  in  4  raw slide-switch pads, asynchronous to clk.
REQ-007 key_level  out  4  debounced key state, 1 = pressed.
REQ-008 key_press  out  4  one-clock pulse per accepted press.
REQ-009 key_release  out  4  one-clock pulse per accepted release.
REQ-010 key_toggle  out  4  level that inverts on each accepted press.
REQ-011 sw_level  out  4  debounced switch state, same polarity as pad.
REQ-012 sw_change  out  4  one-clock pulse per accepted switch change.

Function
REQ-013 Each of the 8 inputs SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Each channel SHALL hold a stable bit and a counter of width clog2(DEBOUNCE_CYCLES).
REQ-015 Counter SHALL clear to 0 in any cycle the synchronized value equals stable, else increment.
REQ-016 When counter == DEBOUNCE_CYCLES-1 and synchronized value still differs, stable SHALL take the synchronized value and counter SHALL clear; counter SHALL never wrap.
REQ-017 Latency from pad edge to level change SHALL be exactly 2 + DEBOUNCE_CYCLES clocks; any opposite glitch shorter than that SHALL restart the count and produce no event.
REQ-018 key_press/key_release/sw_change SHALL be registered, asserted in exactly the cycle the corresponding level output first shows its new value, and low otherwise.
REQ-019 Channels SHALL be independent; simultaneous changes on several channels SHALL produce their events in the same cycle.
REQ-020 key_toggle[i] SHALL invert in the same cycle key_press[i] is high.

Reset
REQ-021 While rst_n=0: key_level, key_press, key_release, key_toggle, sw_level, sw_change SHALL all be 0, all counters 0.
REQ-022 Key synchronizers SHALL reset to the released raw level (1 if KEY_ACTIVE_LOW, else 0); sw synchronizers SHALL reset to 0.
REQ-023 An input already active at reset release SHALL be reported as a normal change (level + pulse) 2 + DEBOUNCE_CYCLES clocks later; reset mid-count SHALL discard the partial count.

Configuration
REQ-024 Macro KEY_DEBOUNCE_TOGGLE_EN defined: toggle registers SHALL be built per REQ-020.
REQ-025 Macro undefined: key_toggle SHALL be tied to 0 and no toggle flops SHALL exist; all other behaviour unchanged.

Structure
REQ-026 Package key_pkg SHALL hold NUM_KEYS=4, NUM_SW=4, DEFAULT_DEBOUNCE_CYCLES=240000 and the counter-width function.
REQ-027 Sub-module debounce_ch (synchronizer + counter + stable bit + change pulse, parameterised reset level) SHALL be instantiated 8 times; polarity inversion and toggle logic SHALL live in key_debounce.

Verification (DEBOUNCE_CYCLES=8, KEY_ACTIVE_LOW=1)
REQ-028 key[0] 1->0 held 20 clocks -> key_level[0]=1 and key_press[0] high for one clock, exactly 10 clocks after the edge.
REQ-029 key[1] pulsed low for 5 clocks, three times 2 clocks apart -> no key_press[1], key_level[1] stays 0.
REQ-030 after REQ-028 press, key[0] 0->1 held -> key_release[0] one-clock pulse and key_level[0]=0 10 clocks later.
REQ-031 two separate accepted presses on key[2] -> key_toggle[2] 0->1->0 with macro defined; stays 0 with macro undefined.
REQ-032 rst_n low for 3 clocks at count 5 of a key[3] press, key held throughout -> all outputs 0 during reset; key_press[3] 10 clocks after rst_n rises.
REQ-033 key[3] and sw[0] change in the same clock -> key_press[3] and sw_change[0] asserted in the same cycle; sw_level[0]=1.

Source files
------------

// File: rtl/key_pkg.sv
// key_pkg: shared sizes and helpers for the key/switch debouncer.
// cnt_width sizes the per-channel stability counter.
package key_pkg;

  localparam int NUM_KEYS = 4;
  localparam int NUM_SW = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 240000;

  function automatic int cnt_width(
    input int unsigned cycles
  );
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one input channel -- 2-flop synchronizer,
// stability counter, accepted level and one-clock change pulse.
module debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic        RST_LEVEL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic stable,
  output logic change
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          accept;

  assign differ = sync[1] ^ stable;
  assign accept = differ && (cnt == LAST);

  // Bring the asynchronous pad into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {2{RST_LEVEL}};
    end else begin
      sync <= {sync[0], din};
    end
  end

  // Count consecutive disagreeing clocks; accept on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= RST_LEVEL;
      change <= 1'b0;
    end else begin
      change <= accept;
      if (!differ || accept) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (accept) begin
        stable <= sync[1];
      end
    end
  end

endmodule

// File: rtl/key_debounce.sv
// key_debounce: 4 push-buttons + 4 slide switches, debounced.
// Define KEY_DEBOUNCE_TOGGLE_EN to build the key_toggle flops.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int          KEY_ACTIVE_LOW  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key,
  input  logic [NUM_SW-1:0]   sw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_toggle,
  output logic [NUM_SW-1:0]   sw_level,
  output logic [NUM_SW-1:0]   sw_change
);

  localparam logic KEY_IDLE = (KEY_ACTIVE_LOW != 0);
  localparam logic [NUM_KEYS-1:0] KEY_INV = {NUM_KEYS{KEY_IDLE}};

  logic [NUM_KEYS-1:0] key_st;
  logic [NUM_KEYS-1:0] key_chg;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RST_LEVEL       (KEY_IDLE)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (key[i]),
      .stable (key_st[i]),
      .change (key_chg[i])
    );
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RST_LEVEL       (1'b0)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (sw[i]),
      .stable (sw_level[i]),
      .change (sw_change[i])
    );
  end

  assign key_level   = key_st ^ KEY_INV;
  assign key_press   = key_chg & key_level;
  assign key_release = key_chg & ~key_level;

`ifdef KEY_DEBOUNCE_TOGGLE_EN
  logic [NUM_KEYS-1:0] tog_q;

  // tog_q lags one clock; xor with press so the flip shows in the press cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog_q <= '0;
    end else begin
      tog_q <= tog_q ^ key_press;
    end
  end

  assign key_toggle = tog_q ^ key_press;
`else
  assign key_toggle = '0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed scenarios plus random pad noise
// checked against a sample-window reference model.
module tb_key_debounce;

  localparam int D  = 8;
  localparam int HL = D + 2;
`ifdef KEY_DEBOUNCE_TOGGLE_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] key = 4'hF;
  logic [3:0] sw = 4'h0;
  logic [3:0] key_level, key_press, key_release;
  logic [3:0] key_toggle, sw_level, sw_change;

  int n_pass = 0;
  int n_chk = 0;

  key_debounce #(
    .DEBOUNCE_CYCLES (D),
    .KEY_ACTIVE_LOW  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key         (key),
    .sw          (sw),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_toggle  (key_toggle),
    .sw_level    (sw_level),
    .sw_change   (sw_change)
  );

  always #5 clk = ~clk;

  // Reference: a channel flips when the D raw samples taken
  // two clocks and more ago all disagree with its level.
  logic [7:0] hist [$];
  logic [7:0] m_st;
  logic [7:0] m_chg;
  logic [3:0] m_tog;
  int m_agree;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      for (int j = 0; j < HL; j++) hist.push_back(8'h0F);
      m_st = 8'h0F;
      m_chg = '0;
      m_tog = '0;
    end else begin
      hist.push_back({sw, key});
      void'(hist.pop_front());
      m_chg = '0;
      for (int c = 0; c < 8; c++) begin
        m_agree = 0;
        for (int j = 0; j < D; j++)
          if (hist[j][c] == m_st[c]) m_agree++;
        if (m_agree == 0) begin
          m_st[c] = ~m_st[c];
          m_chg[c] = 1'b1;
        end
      end
      m_tog = m_tog ^ (m_chg[3:0] & ~m_st[3:0]);
    end
  end

  logic [3:0] e_kl;
  logic [23:0] exp_v;
  logic [23:0] obs_v;
  assign e_kl = ~m_st[3:0];
  assign exp_v = {e_kl, m_chg[3:0] & e_kl,
                  m_chg[3:0] & ~e_kl,
                  TOG ? m_tog : 4'h0,
                  m_st[7:4], m_chg[7:4]};
  assign obs_v = {key_level, key_press, key_release,
                  key_toggle, sw_level, sw_change};

  task automatic test_reset();
    rst_n = 1'b0;
    key = 4'hF;
    sw = 4'h0;
    repeat (3) begin
      @(negedge clk);
      n_chk++;
      if (obs_v !== 24'h0)
        $display("FAIL reset: got %h want %h", obs_v, 24'h0);
      else n_pass++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_chk++;
      if (obs_v !== exp_v)
        $display("FAIL post_reset: got %h want %h", obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_press();
    @(posedge clk); #1;
    key[0] = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) @(negedge clk);
      else @(negedge clk);
      n_chk++;
      if (obs_v !== exp_v || key_press[0] !== (c == 10)
          || key_level[0] !== (c >= 10))
        $display("FAIL press c=%0d: got %h want %h p0=%b l0=%b",
                 c, obs_v, exp_v, key_press[0], key_level[0]);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    for (int c = 0; c <= 32; c++) begin
      @(posedge clk); #1;
      key[1] = (c < 21 && (c % 7) < 5) ? 1'b0 : 1'b1;
      @(negedge clk);
      n_chk++;
      if (obs_v !== exp_v || key_press[1] !== 1'b0
          || key_level[1] !== 1'b0)
        $display("FAIL glitch c=%0d: got %h want %h p1=%b l1=%b",
                 c, obs_v, exp_v, key_press[1], key_level[1]);
      else n_pass++;
    end
  endtask

  task automatic test_release();
    @(posedge clk); #1;
    key[0] = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      n_chk++;
      if (obs_v !== exp_v || key_release[0] !== (c == 10)
          || key_level[0] !== (c < 10))
        $display("FAIL release c=%0d: got %h want %h r0=%b l0=%b",
                 c, obs_v, exp_v, key_release[0], key_level[0]);
      else n_pass++;
    end
  endtask

  task automatic test_toggle();
    logic exp_t;
    for (int c = 0; c <= 47; c++) begin
      @(posedge clk); #1;
      key[2] = (c < 12 || (c >= 24 && c < 36)) ? 1'b0 : 1'b1;
      @(negedge clk);
      exp_t = (c >= 10 && c < 34) ? TOG : 1'b0;
      n_chk++;
      if (obs_v !== exp_v || key_toggle[2] !== exp_t)
        $display("FAIL toggle c=%0d: got %h want %h t2=%b want %b",
                 c, obs_v, exp_v, key_toggle[2], exp_t);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    key[3] = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      n_chk++;
      if (obs_v !== exp_v)
        $display("FAIL rstmid_pre c=%0d: got %h want %h",
                 c, obs_v, exp_v);
      else n_pass++;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_chk++;
      if (obs_v !== 24'h0)
        $display("FAIL rstmid_hold: got %h want %h", obs_v, 24'h0);
      else n_pass++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      n_chk++;
      if (obs_v !== exp_v || key_press[3] !== (c == 10))
        $display("FAIL rstmid c=%0d: got %h want %h p3=%b",
                 c, obs_v, exp_v, key_press[3]);
      else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    @(posedge clk); #1;
    key[3] = 1'b1;
    repeat (12) begin
      @(negedge clk);
      n_chk++;
      if (obs_v !== exp_v)
        $display("FAIL simul_pre: got %h want %h", obs_v, exp_v);
      else n_pass++;
    end
    @(posedge clk); #1;
    key[3] = 1'b0;
    sw[0] = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      n_chk++;
      if (obs_v !== exp_v || key_press[3] !== (c == 10)
          || sw_change[0] !== (c == 10)
          || sw_level[0] !== (c >= 10))
        $display("FAIL simul c=%0d: got %h want %h p3=%b sc0=%b sl0=%b",
                 c, obs_v, exp_v, key_press[3], sw_change[0],
                 sw_level[0]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int hold [8];
    int rcnt;
    logic [7:0] pads;
    rcnt = 0;
    pads = {sw, key};
    for (int i = 0; i < 8; i++) hold[i] = $urandom_range(1, 2 * D + 2);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          pads[i] = ~pads[i];
          hold[i] = $urandom_range(1, 2 * D + 2);
        end
      end
      {sw, key} = pads;
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) rst_n = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        rcnt = 2;
      end
      @(negedge clk);
      n_chk++;
      if (obs_v !== exp_v)
        $display("FAIL random c=%0d: got %h want %h", c, obs_v, exp_v);
      else n_pass++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_release();
    test_toggle();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
